mux_select_sequencer: RTL and testbench

Round-robin scan controller that sits directly upstream of the transmission-gate 4:1 mux. It drives the mux select pair (s1, s0), waits a programmable settle time per channel, and registers the mux output z back into a 4-bit sample word. Scans are started by a one-cycle request and report completion with a done pulse. Scans can optionally repeat continuously.

---
 rtl/mux_select_sequencer.sv | 145 ++++++++++++++
 tb/tb_mux_select_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Round-robin scan controller for a 4:1 transmission-gate mux. It steps the
// select pair over the enabled channels, lets each settle, and captures z per channel.
module mux_select_sequencer #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       continuous,
  input  logic [3:0] mask,
  input  logic       z,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample,
  output logic [3:0] valid_mask,
  output logic [7:0] scan_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t      state, state_nx;
  logic [1:0]  ch, ch_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  mask_q, mask_nx;
  logic [3:0]  sample_nx, valid_nx, higher;
  logic [7:0]  count_nx;
  logic [1:0]  sel_nx;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  // Select encoding: s1 = ~ch[0], s0 = ~ch[1].
  function automatic logic [1:0] enc(input logic [1:0] c);
    return {~c[0], ~c[1]};
  endfunction

  always_comb begin
    state_nx  = state;
    ch_nx     = ch;
    cnt_nx    = cnt;
    mask_nx   = mask_q;
    sample_nx = sample;
    valid_nx  = valid_mask;
    count_nx  = scan_count;
    sel_nx    = {s1, s0};
    higher    = mask_q & (4'b1110 << ch);
    case (state)
      ST_IDLE: begin
        sel_nx = 2'b11;
        if (start && mask != 4'd0) begin
          mask_nx   = mask;
          sample_nx = 4'd0;
          ch_nx     = lowest(mask);
          cnt_nx    = RELOAD;
          sel_nx    = enc(lowest(mask));
          state_nx  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nx = ST_IDLE;
          sel_nx   = 2'b11;
        end else if (cnt == 4'd0) begin
          state_nx = ST_SAMPLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_nx = ST_IDLE;
          sel_nx   = 2'b11;
        end else begin
          sample_nx[ch] = z;
          if (higher != 4'd0) begin
            ch_nx    = lowest(higher);
            cnt_nx   = RELOAD;
            sel_nx   = enc(lowest(higher));
            state_nx = ST_SETTLE;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        valid_nx = mask_q;
        count_nx = scan_count + 8'd1;
        // An abort landing on DONE only cancels the automatic rescan.
        if (continuous && !abort && mask != 4'd0) begin
          mask_nx   = mask;
          sample_nx = 4'd0;
          ch_nx     = lowest(mask);
          cnt_nx    = RELOAD;
          sel_nx    = enc(lowest(mask));
          state_nx  = ST_SETTLE;
        end else begin
          sel_nx   = 2'b11;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        sel_nx   = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch         <= 2'd0;
      cnt        <= 4'd0;
      mask_q     <= 4'd0;
      sample     <= 4'd0;
      valid_mask <= 4'd0;
      scan_count <= 8'd0;
      s1         <= 1'b1;
      s0         <= 1'b1;
    end else begin
      state      <= state_nx;
      ch         <= ch_nx;
      cnt        <= cnt_nx;
      mask_q     <= mask_nx;
      sample     <= sample_nx;
      valid_mask <= valid_nx;
      scan_count <= count_nx;
      s1         <= sel_nx[1];
      s0         <= sel_nx[0];
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: a behavioural mux model drives z, and a
// scan-timeline model built from the enabled-channel list supplies expected values.
module tb_mux_select_sequencer;

  logic       clk, rst_n, start, abort, continuous;
  logic [3:0] mask;
  logic       z, s1, s0, busy, done;
  logic [3:0] sample, valid_mask;
  logic [7:0] scan_count;
  logic       c_z, c_s1, c_s0, c_busy, c_done;
  logic [3:0] c_sample, c_valid_mask;
  logic [7:0] c_scan_count;

  logic [3:0] data0, data1;
  int errors = 0;
  int checks = 0;
  int exp_count;
  logic [3:0] exp_valid;
  logic [1:0] m_sel [0:127];
  int m_len;

  mux_select_sequencer #(.SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .mask(mask), .z(z), .s1(s1), .s0(s0), .busy(busy), .done(done),
    .sample(sample), .valid_mask(valid_mask), .scan_count(scan_count));

  mux_select_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .mask(mask), .z(c_z), .s1(c_s1), .s0(c_s0), .busy(c_busy), .done(c_done),
    .sample(c_sample), .valid_mask(c_valid_mask), .scan_count(c_scan_count));

  // Mux model: {s1,s0}=11 selects a, 01 b, 10 c, 00 d.
  assign z   = data0[{~s0, ~s1}];
  assign c_z = data1[{~c_s0, ~c_s1}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input int c);
    case (c)
      0: return 2'b11;
      1: return 2'b01;
      2: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Expected select per cycle after the start edge; the last entry is the DONE cycle.
  function void build_model(input logic [3:0] m, input int s);
    logic [1:0] last;
    last = 2'b11;
    m_len = 0;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int r = 0; r < s + 1; r++) begin
          m_sel[m_len] = enc(c);
          last = enc(c);
          m_len++;
        end
    m_sel[m_len] = last;
    m_len++;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0; mask = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    exp_valid = 4'd0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({s1, s0} !== 2'b11) begin errors++; $display("FAIL rst_sel got=%b exp=11", {s1, s0}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (sample !== 4'd0) begin errors++; $display("FAIL rst_sample got=%b exp=0000", sample); end
    checks++; if (valid_mask !== 4'd0) begin errors++; $display("FAIL rst_valid got=%b exp=0000", valid_mask); end
    checks++; if (scan_count !== 8'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", scan_count); end
    data0 = 4'b0001; mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (sample !== 4'b0001) begin errors++; $display("FAIL mid_sample got=%b exp=0001", sample); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({s1, s0} !== 2'b11) begin errors++; $display("FAIL async_sel got=%b exp=11", {s1, s0}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_done got=%b exp=0", done); end
    checks++; if (sample !== 4'd0) begin errors++; $display("FAIL async_sample got=%b exp=0000", sample); end
    checks++; if (scan_count !== 8'd0) begin errors++; $display("FAIL async_count got=%0d exp=0", scan_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full, sparse and random-mask scans back to back, with start/mask noise mid-scan.
  task automatic test_scan_patterns();
    logic [3:0] m, d, exp_sample;
    do_reset();
    for (int t = 0; t < 14; t++) begin
      m = (t == 0) ? 4'b1111 : (t == 1) ? 4'b1010 : 4'($urandom_range(1, 15));
      d = (t == 0) ? 4'b0101 : (t == 1) ? 4'b1111 : 4'($urandom_range(0, 15));
      data0 = d; mask = m; start = 1'b1;
      build_model(m, 2);
      exp_sample = d & m;
      @(negedge clk);
      for (int k = 1; k <= m_len + 1; k++) begin
        checks++;
        if ({s1, s0} !== ((k <= m_len) ? m_sel[k-1] : 2'b11)) begin
          errors++; $display("FAIL scan_sel t=%0d cyc=%0d got=%b exp=%b", t, k, {s1, s0}, (k <= m_len) ? m_sel[k-1] : 2'b11);
        end
        checks++;
        if (busy !== (k <= m_len)) begin errors++; $display("FAIL scan_busy t=%0d cyc=%0d got=%b", t, k, busy); end
        checks++;
        if (done !== (k == m_len)) begin errors++; $display("FAIL scan_done t=%0d cyc=%0d got=%b", t, k, done); end
        if (k <= m_len) begin
          start = 1'($urandom_range(0, 1));
          mask  = 4'($urandom_range(0, 15));
          @(negedge clk);
        end
      end
      exp_count = (exp_count + 1) % 256;
      exp_valid = m;
      checks++; if (sample !== exp_sample) begin errors++; $display("FAIL scan_sample t=%0d got=%b exp=%b", t, sample, exp_sample); end
      checks++; if (valid_mask !== m) begin errors++; $display("FAIL scan_valid t=%0d got=%b exp=%b", t, valid_mask, m); end
      checks++; if (scan_count !== 8'(exp_count)) begin errors++; $display("FAIL scan_count t=%0d got=%0d exp=%0d", t, scan_count, exp_count); end
      start = 1'b0;
    end
  endtask

  task automatic test_zero_mask();
    mask = 4'd0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_mask cyc=%0d busy=%b done=%b exp=0,0", k, busy, done); end
      checks++; if (scan_count !== 8'(exp_count)) begin errors++; $display("FAIL zero_count got=%0d exp=%0d", scan_count, exp_count); end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    logic [3:0] d;
    d = 4'($urandom_range(0, 15)) | 4'b0010;
    data0 = d; mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if ({s1, s0} !== 2'b11) begin errors++; $display("FAIL abort_sel got=%b exp=11", {s1, s0}); end
    checks++; if (sample[0] !== d[0]) begin errors++; $display("FAIL abort_s0 got=%b exp=%b", sample[0], d[0]); end
    checks++; if (sample[1] !== 1'b0) begin errors++; $display("FAIL abort_s1 got=%b exp=0", sample[1]); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle cyc=%0d done=%b busy=%b", k, done, busy); end
      @(negedge clk);
    end
    checks++; if (scan_count !== 8'(exp_count)) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", scan_count, exp_count); end
    checks++; if (valid_mask !== exp_valid) begin errors++; $display("FAIL abort_valid got=%b exp=%b", valid_mask, exp_valid); end
  endtask

  // SETTLE=1 instance: scans of 3 cycles, 257 scans, then continuous dropped.
  task automatic test_continuous();
    int kk;
    do_reset();
    data1 = 4'($urandom_range(0, 15));
    mask = 4'b0001; continuous = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 775; k++) begin
      kk = (k > 772) ? 772 : k;
      checks++; if (c_done !== ((k % 3 == 0) && k <= 771)) begin errors++; $display("FAIL cont_done cyc=%0d got=%b", k, c_done); end
      checks++; if (c_busy !== (k <= 771)) begin errors++; $display("FAIL cont_busy cyc=%0d got=%b", k, c_busy); end
      checks++; if (c_scan_count !== 8'(((kk - 1) / 3) % 256)) begin errors++; $display("FAIL cont_count cyc=%0d got=%0d exp=%0d", k, c_scan_count, ((kk - 1) / 3) % 256); end
      checks++; if ({c_s1, c_s0} !== 2'b11) begin errors++; $display("FAIL cont_sel cyc=%0d got=%b exp=11", k, {c_s1, c_s0}); end
      if (k == 771) begin
        checks++; if (c_sample !== {3'b000, data1[0]}) begin errors++; $display("FAIL cont_sample got=%b exp=%b", c_sample, {3'b000, data1[0]}); end
      end
      if (k == 772) begin
        checks++; if (c_valid_mask !== 4'b0001) begin errors++; $display("FAIL cont_valid got=%b exp=0001", c_valid_mask); end
      end
      if (k == 770) continuous = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    data0 = 4'd0; data1 = 4'd0;
    test_reset();
    test_scan_patterns();
    test_zero_mask();
    test_abort();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
